param_sync_fifo: RTL

//   Parametrised single-clock FIFO with wrap-bit pointers, almost-full/almost-empty thresholds,

---
 rtl/param_sync_fifo_pkg.sv | 17 +
 rtl/param_sync_fifo_if.sv | 43 ++++
 rtl/param_sync_fifo_ram.sv | 48 ++++
 rtl/param_sync_fifo.sv | 109 ++++++++++
 4 files changed

// File: rtl/param_sync_fifo_pkg.sv
// Package pfifo_pkg: shared defaults for the parametrised synchronous FIFO.
// Holds the default word and address widths, a helper that turns an address
// width into a word depth, and the pointer type used at the default widths.
package pfifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    // Number of words addressed by an address bus of addr_w bits.
    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Pointer at default widths: ADDR_W address bits plus one wrap bit.
    typedef logic [DEF_ADDR_W:0] ptr_t;

endpackage

// File: rtl/param_sync_fifo_if.sv
// Interface pfifo_if: producer/consumer bus of the synchronous FIFO.
//   wr_en, wr_data           write request and word
//   rd_en                    read request (pop acknowledge in FWFT mode)
//   rd_data, rd_valid        read word and its qualifier
//   full, empty              occupancy extremes
//   almost_full/almost_empty threshold flags
//   count                    words stored, 0..DEPTH
//   overflow, underflow      one-cycle error pulses
// Modport master: the side that drives requests (producer/consumer).
// Modport slave:  the FIFO itself.
interface pfifo_if
    import pfifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/param_sync_fifo_ram.sv
// Module pfifo_ram: storage array for the synchronous FIFO.
//   clk, reset   clock and async active-high reset (read register only)
//   we, waddr, wdata   synchronous write port
//   re, raddr, rdata   read port
// Macro PFIFO_FWFT_EN selects the read port style:
//   undefined: registered read, rdata updates on an edge where re is high
//              and holds otherwise; cleared by reset
//   defined:   asynchronous read, rdata = mem[raddr]
// The array itself is never reset.
module pfifo_ram
    import pfifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [depth(ADDR_W)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef PFIFO_FWFT_EN
    assign rdata = mem[raddr];
`else
    // Read register: a same-edge write can never target raddr, because a
    // write is only accepted when not full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Module param_sync_fifo: parametrised single-clock FIFO.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    pfifo_if.slave carrying requests, data, flags, count, error pulses
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), AFULL_TH, AEMPTY_TH.
// Pointers carry an extra wrap bit so full and empty are distinguishable;
// all flags and the count are decoded from the registered pointers.
// Macro PFIFO_FWFT_EN enables first-word-fall-through reads; undefined gives
// a registered read with a one-cycle rd_valid pulse per accepted read.
module param_sync_fifo
    import pfifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = depth(ADDR_W) - 4,
    parameter int AEMPTY_TH = 4
) (
    input logic   clk,
    input logic   reset,
    pfifo_if.slave bus
);

    localparam logic [ADDR_W:0] AFULL_LVL  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_LVL = AEMPTY_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   fill;
    logic              full_i;
    logic              empty_i;
    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] ram_rdata;

    // Same address with differing wrap bits means the writer is a full lap ahead.
    assign full_i  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign empty_i = (wr_ptr == rd_ptr);
    assign fill    = wr_ptr - rd_ptr;

    // Both requests are judged on the pre-edge flags, so a full FIFO can
    // still be read and an empty one still be written in the same cycle.
    assign wr_accept = bus.wr_en && !full_i;
    assign rd_accept = bus.rd_en && !empty_i;

    assign bus.full         = full_i;
    assign bus.empty        = empty_i;
    assign bus.count        = fill;
    assign bus.almost_full  = (fill >= AFULL_LVL);
    assign bus.almost_empty = (fill <= AEMPTY_LVL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Error pulses flag the rejected request one cycle after its edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.overflow  <= bus.wr_en && full_i;
            bus.underflow <= bus.rd_en && empty_i;
        end
    end

    pfifo_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (wr_accept),
        .waddr(wr_ptr[ADDR_W-1:0]),
        .wdata(bus.wr_data),
        .re   (rd_accept),
        .raddr(rd_ptr[ADDR_W-1:0]),
        .rdata(ram_rdata)
    );

`ifdef PFIFO_FWFT_EN
    // The head word is presented whenever one is stored; an empty FIFO
    // shows zero rather than stale memory contents.
    assign bus.rd_valid = !empty_i;
    assign bus.rd_data  = empty_i ? '0 : ram_rdata;
`else
    assign bus.rd_data = ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= rd_accept;
        end
    end
`endif

endmodule
